bfp_decomp_arbiter: RTL and testbench

BFP_DECOMP_ARBITER -- requirements
Module: bfp_decomp_arbiter

---
 rtl/bfp_pkg.sv | 35 +++
 rtl/bfp_axis_reg_slice.sv | 46 ++++
 rtl/bfp_decomp_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bfp_decomp_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfp_pkg.sv
// bfp_pkg: udCompHdr field layout, supported compression methods and the
// AXI-Stream beat payload shared by the BFP decompression arbiter.
package bfp_pkg;

   localparam int unsigned AXIS_DW = 64;
   localparam int unsigned AXIS_KW = 8;
   localparam int unsigned AXIS_UW = 40;

   localparam int unsigned UD_IQ_WIDTH_MSB = 39;
   localparam int unsigned UD_IQ_WIDTH_LSB = 36;
   localparam int unsigned UD_METH_MSB     = 35;
   localparam int unsigned UD_METH_LSB     = 32;

   localparam logic [3:0] UD_COMP_METH_NONE = 4'h0;
   localparam logic [3:0] UD_COMP_METH_BFP  = 4'h1;

   // udCompHdr as carried on tuser of a packet's first beat
   typedef struct packed {
      logic [UD_IQ_WIDTH_MSB-UD_IQ_WIDTH_LSB:0] iq_width;
      logic [UD_METH_MSB-UD_METH_LSB:0]         comp_meth;
      logic [UD_METH_LSB-1:0]                   rsvd;
   } ud_comp_hdr_t;

   typedef struct packed {
      ud_comp_hdr_t         tuser;
      logic [AXIS_KW-1:0]   tkeep;
      logic                 tlast;
      logic [AXIS_DW-1:0]   tdata;
   } axis_beat_t;

   function automatic logic meth_supported(input ud_comp_hdr_t hdr);
      return (hdr.comp_meth == UD_COMP_METH_NONE) || (hdr.comp_meth == UD_COMP_METH_BFP);
   endfunction

endpackage

// File: rtl/bfp_axis_reg_slice.sv
// bfp_axis_reg_slice: 2-entry skid register slice; registered valid on the
// output side, ready on the input side derived only from the skid flag.
module bfp_axis_reg_slice #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready
);

   logic          skid_valid;
   logic [DW-1:0] skid_data;
   logic          s_fire;
   logic          load_main;

   assign s_ready   = ~skid_valid;
   assign s_fire    = s_valid & s_ready;
   assign load_main = ~m_valid | m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid    <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load_main) begin
         m_valid    <= skid_valid | s_fire;
         skid_valid <= 1'b0;
      end else if (s_fire) begin
         skid_valid <= 1'b1;
      end
   end

   // Output stage drains the skid entry before taking new input, preserving order
   always_ff @(posedge clk) begin
      if (load_main) begin
         m_data <= skid_valid ? skid_data : s_data;
      end else if (s_fire) begin
         skid_data <= s_data;
      end
   end

endmodule

// File: rtl/bfp_decomp_arbiter.sv
// bfp_decomp_arbiter: packet-granular round-robin merge of NUM_CH compressed-section
// streams into one stream. Optional per-channel packet counters under BFP_ARB_STATS_EN.
module bfp_decomp_arbiter
   import bfp_pkg::*;
#(
   parameter int unsigned NUM_CH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0][AXIS_DW-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0][AXIS_KW-1:0] s_axis_tkeep,
   input  logic [NUM_CH-1:0]              s_axis_tvalid,
   input  logic [NUM_CH-1:0]              s_axis_tlast,
   output logic [NUM_CH-1:0]              s_axis_tready,
   input  logic [NUM_CH-1:0][AXIS_UW-1:0] s_axis_tuser,
   output logic [AXIS_DW-1:0]             m_axis_tdata,
   output logic [AXIS_KW-1:0]             m_axis_tkeep,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic [AXIS_UW-1:0]             m_axis_tuser,
   output logic [$clog2(NUM_CH)-1:0]      m_axis_tid,
   output logic                           err_bad_meth
`ifdef BFP_ARB_STATS_EN
   ,
   output logic [NUM_CH-1:0][31:0]        pkt_cnt
`endif
);

   localparam int unsigned GW = $clog2(NUM_CH);
   localparam int unsigned BW = $bits(axis_beat_t) + GW;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic          first_q, first_d;
   logic          err_d;

   logic [GW-1:0] rr_pick;
   logic [GW-1:0] rr_cand;
   logic          rr_found;

   logic          in_valid;
   logic          accept;
   logic          tlast_fire;
   logic          slice_ready;
   axis_beat_t    in_beat;
   axis_beat_t    out_beat;
   logic [BW-1:0] slice_in;
   logic [BW-1:0] slice_out;

   // First valid channel after last_grant in ascending modulo order
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_cand  = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         rr_cand = GW'((32'(last_grant_q) + i) % NUM_CH);
         if (!rr_found && s_axis_tvalid[rr_cand]) begin
            rr_found = 1'b1;
            rr_pick  = rr_cand;
         end
      end
   end

   always_comb begin
      in_beat.tdata = s_axis_tdata[grant_q];
      in_beat.tkeep = s_axis_tkeep[grant_q];
      in_beat.tlast = s_axis_tlast[grant_q];
      in_beat.tuser = ud_comp_hdr_t'(s_axis_tuser[grant_q]);
   end

   // Next-state, handshake and error decode
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      first_d       = first_q;
      s_axis_tready = '0;
      in_valid      = 1'b0;
      accept        = 1'b0;
      tlast_fire    = 1'b0;
      err_d         = 1'b0;
      case (state_q)
         IDLE: begin
            if (rr_found) begin
               grant_d = rr_pick;
               first_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            s_axis_tready[grant_q] = slice_ready;
            in_valid               = s_axis_tvalid[grant_q];
            accept                 = in_valid & slice_ready;
            tlast_fire             = accept & in_beat.tlast;
            err_d                  = accept & first_q & ~meth_supported(in_beat.tuser);
            if (accept) begin
               first_d = 1'b0;
            end
            if (tlast_fire) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_CH - 1);
         first_q      <= 1'b0;
         err_bad_meth <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         err_bad_meth <= err_d;
      end
   end

   assign slice_in = {grant_q, in_beat};

   bfp_axis_reg_slice #(
      .DW (BW)
   ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (slice_in),
      .s_valid (in_valid),
      .s_ready (slice_ready),
      .m_data  (slice_out),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign {m_axis_tid, out_beat} = slice_out;
   assign m_axis_tdata = out_beat.tdata;
   assign m_axis_tkeep = out_beat.tkeep;
   assign m_axis_tlast = out_beat.tlast;
   assign m_axis_tuser = out_beat.tuser;

`ifdef BFP_ARB_STATS_EN
   // Wrapping count of completed packets per channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
      end else if (tlast_fire) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_q == GW'(c)) begin
               pkt_cnt[c] <= pkt_cnt[c] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_bfp_decomp_arbiter.sv
// tb_bfp_decomp_arbiter: randomized packet traffic checked against a queue-based
// round-robin packet model and an in-order FIFO scoreboard of accepted beats.
module tb_bfp_decomp_arbiter;

   localparam int NCH = 4;
   localparam int TW  = 2;

   typedef struct packed {
      logic [TW-1:0] tid;
      logic [39:0]   user;
      logic          last;
      logic [7:0]    keep;
      logic [63:0]   data;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NCH-1:0][63:0]  s_tdata;
   logic [NCH-1:0][7:0]   s_tkeep;
   logic [NCH-1:0]        s_tvalid;
   logic [NCH-1:0]        s_tlast;
   logic [NCH-1:0]        s_tready;
   logic [NCH-1:0][39:0]  s_tuser;
   logic [63:0]           m_tdata;
   logic [7:0]            m_tkeep;
   logic                  m_tvalid;
   logic                  m_tlast;
   logic                  m_tready;
   logic [39:0]           m_tuser;
   logic [TW-1:0]         m_tid;
   logic                  err;
`ifdef BFP_ARB_STATS_EN
   logic [NCH-1:0][31:0]  pkt_cnt;
`endif

   always #5 clk = ~clk;

   bfp_decomp_arbiter #(.NUM_CH(NCH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .m_axis_tuser  (m_tuser),
      .m_axis_tid    (m_tid),
      .err_bad_meth  (err)
`ifdef BFP_ARB_STATS_EN
      ,
      .pkt_cnt       (pkt_cnt)
`endif
   );

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t pend [NCH][$];
   beat_t acc_q [$];
   int    out_tids [$];
   bit    in_pkt;
   int    cur_ch;
   int    last_grant;
   bit    first_of_pkt [NCH];
   bit    exp_err;
   int    pkt_model [NCH];

   task automatic reset_model();
      for (int c = 0; c < NCH; c++) begin
         pend[c].delete();
         first_of_pkt[c] = 1'b1;
         pkt_model[c] = 0;
      end
      acc_q.delete();
      out_tids.delete();
      in_pkt = 1'b0;
      cur_ch = 0;
      last_grant = NCH - 1;
      exp_err = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      s_tvalid = '0;
      s_tlast = '0;
      m_tready = 1'b1;
      reset_model();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // meth < 0 picks a random method, mostly supported ones
   task automatic gen_pkt(input int c, input int len, input int meth);
      beat_t b;
      logic [3:0] m;
      if (meth >= 0) m = 4'(meth);
      else if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(2, 15));
      else m = 4'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
         b.tid  = TW'(c);
         b.data = {32'($urandom), 32'($urandom)};
         b.keep = 8'($urandom);
         b.user = {4'($urandom), m, 32'($urandom)};
         b.last = (i == len - 1);
         pend[c].push_back(b);
      end
   endtask

   function automatic int rr_expected();
      for (int i = 1; i <= NCH; i++) begin
         if (pend[(last_grant + i) % NCH].size() > 0) return (last_grant + i) % NCH;
      end
      return -1;
   endfunction

   task automatic update_drives(input bit gaps, input int rmode);
      beat_t b;
      for (int c = 0; c < NCH; c++) begin
         if (pend[c].size() > 0 && (first_of_pkt[c] || !gaps || $urandom_range(0, 3) != 0)) begin
            b = pend[c][0];
            s_tvalid[c] = 1'b1;
            s_tdata[c]  = b.data;
            s_tkeep[c]  = b.keep;
            s_tuser[c]  = b.user;
            s_tlast[c]  = b.last;
         end else begin
            s_tvalid[c] = 1'b0;
            s_tlast[c]  = 1'b0;
            s_tdata[c]  = {32'($urandom), 32'($urandom)};
         end
      end
      case (rmode)
         0: m_tready = 1'b1;
         1: m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Drive pending packets; inputs change 1 unit after posedge, sampling on negedge
   task automatic run_traffic(input int max_cycles, input int rmode, input bit gaps, input int stop_acc);
      int cyc;
      int n_acc;
      int exp_c;
      bit done;
      bit empty;
      beat_t b;
      beat_t got;
      cyc = 0;
      n_acc = 0;
      done = 1'b0;
      update_drives(gaps, rmode);
      while (!done) begin
         @(negedge clk);
         n_cmp++;
         if (err !== exp_err) begin
            n_err++;
            $display("FAIL err_bad_meth: got %b expected %b at %0t", err, exp_err, $time);
         end
         exp_err = 1'b0;
         if (m_tvalid === 1'b1 && m_tready) begin
            got.tid = m_tid; got.user = m_tuser; got.last = m_tlast;
            got.keep = m_tkeep; got.data = m_tdata;
            n_cmp++;
            if (acc_q.size() == 0) begin
               n_err++;
               $display("FAIL spurious_beat: got tid %0d data %h, expected no beat", m_tid, m_tdata);
            end else begin
               b = acc_q.pop_front();
               if (got !== b) begin
                  n_err++;
                  $display("FAIL out_beat: got tid %0d last %b data %h user %h, expected tid %0d last %b data %h user %h",
                           got.tid, got.last, got.data, got.user, b.tid, b.last, b.data, b.user);
               end
               out_tids.push_back(int'(m_tid));
            end
         end
         n_cmp++;
         if ($countones(s_tready) > 1) begin
            n_err++;
            $display("FAIL tready_onehot: got %b, expected at most one bit set", s_tready);
         end
         for (int c = 0; c < NCH; c++) begin
            if (s_tvalid[c] && s_tready[c] === 1'b1) begin
               exp_c = in_pkt ? cur_ch : rr_expected();
               n_cmp++;
               if (c != exp_c) begin
                  n_err++;
                  $display("FAIL grant: got channel %0d, expected channel %0d", c, exp_c);
               end
               b = pend[c].pop_front();
               if (!in_pkt && b.user[35:32] != 4'h0 && b.user[35:32] != 4'h1) exp_err = 1'b1;
               acc_q.push_back(b);
               first_of_pkt[c] = b.last;
               in_pkt = !b.last;
               cur_ch = c;
               if (b.last) begin
                  last_grant = c;
                  pkt_model[c]++;
               end
               n_acc++;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (stop_acc > 0 && n_acc >= stop_acc) begin
            done = 1'b1;
         end else begin
            update_drives(gaps, rmode);
            empty = (acc_q.size() == 0);
            for (int c = 0; c < NCH; c++) if (pend[c].size() > 0) empty = 1'b0;
            if (empty) begin
               done = 1'b1;
            end else if (cyc >= max_cycles) begin
               n_cmp++;
               n_err++;
               $display("FAIL timeout: got %0d beats still queued after %0d cycles, expected 0", acc_q.size(), cyc);
               done = 1'b1;
            end
         end
      end
      s_tvalid = '0;
      s_tlast = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s_tvalid = '1;
      m_tready = 1'b1;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b0 || s_tready !== '0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got tvalid %b tready %b err %b, expected 0 0000 0", m_tvalid, s_tready, err);
      end
`ifdef BFP_ARB_STATS_EN
      n_cmp++;
      if (pkt_cnt !== '0) begin
         n_err++;
         $display("FAIL reset_pkt_cnt: got %h, expected 0", pkt_cnt);
      end
`endif
      s_tvalid = '0;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (s_tready !== '0) begin
         n_err++;
         $display("FAIL idle_tready: got %b, expected 0000", s_tready);
      end
   endtask

   task automatic test_two_channels();
      int exp_t [6] = '{0, 0, 0, 2, 2, 2};
      apply_reset();
      gen_pkt(0, 3, -1);
      gen_pkt(2, 3, -1);
      run_traffic(200, 0, 1'b0, 0);
      n_cmp++;
      if (out_tids.size() != 6) begin
         n_err++;
         $display("FAIL two_ch_count: got %0d beats, expected 6", out_tids.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_tids[i] != exp_t[i]) begin
               n_err++;
               $display("FAIL two_ch_tid[%0d]: got %0d, expected %0d", i, out_tids[i], exp_t[i]);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int p = 0; p < 4; p++)
         for (int c = 0; c < NCH; c++) gen_pkt(c, 2, -1);
      run_traffic(500, 0, 1'b0, 0);
      n_cmp++;
      if (out_tids.size() != 32) begin
         n_err++;
         $display("FAIL rr_count: got %0d beats, expected 32", out_tids.size());
      end else begin
         for (int i = 0; i < 32; i += 2) begin
            n_cmp++;
            if (out_tids[i] != (i / 2) % NCH) begin
               n_err++;
               $display("FAIL rr_tid[%0d]: got %0d, expected %0d", i, out_tids[i], (i / 2) % NCH);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      out_tids.delete();
      gen_pkt(1, 5, 1);
      run_traffic(200, 1, 1'b0, 0);
      n_cmp++;
      if (out_tids.size() != 5) begin
         n_err++;
         $display("FAIL bp_count: got %0d beats, expected 5", out_tids.size());
      end
   endtask

   task automatic test_bad_meth();
      out_tids.delete();
      gen_pkt(3, 3, 3);
      gen_pkt(3, 2, 0);
      run_traffic(200, 0, 1'b0, 0);
      n_cmp++;
      if (out_tids.size() != 5) begin
         n_err++;
         $display("FAIL bad_meth_count: got %0d beats, expected 5", out_tids.size());
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < NCH; c++)
            repeat ($urandom_range(0, 3)) gen_pkt(c, int'($urandom_range(1, 6)), -1);
         run_traffic(5000, 2, 1'b1, 0);
      end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      gen_pkt(0, 4, 0);
      run_traffic(100, 0, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (m_tvalid !== 1'b0 || s_tready !== '0) begin
         n_err++;
         $display("FAIL mid_reset: got tvalid %b tready %b, expected 0 0000", m_tvalid, s_tready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_model();
      gen_pkt(0, 4, 1);
      run_traffic(100, 0, 1'b0, 0);
      n_cmp++;
      if (out_tids.size() != 4) begin
         n_err++;
         $display("FAIL post_reset_count: got %0d beats, expected 4", out_tids.size());
      end
   endtask

`ifdef BFP_ARB_STATS_EN
   task automatic test_stats();
      int exp_cnt [NCH] = '{0, 3, 1, 0};
      apply_reset();
      for (int p = 0; p < 3; p++) gen_pkt(1, int'($urandom_range(1, 4)), -1);
      gen_pkt(2, 2, -1);
      run_traffic(300, 2, 1'b1, 0);
      for (int c = 0; c < NCH; c++) begin
         n_cmp++;
         if (pkt_cnt[c] !== 32'(exp_cnt[c])) begin
            n_err++;
            $display("FAIL pkt_cnt[%0d]: got %0d, expected %0d", c, pkt_cnt[c], exp_cnt[c]);
         end
      end
   endtask
`endif

   initial begin
      s_tdata = '0;
      s_tkeep = '0;
      s_tuser = '0;
      s_tvalid = '0;
      s_tlast = '0;
      m_tready = 1'b1;
      test_reset();
      test_two_channels();
      test_round_robin();
      test_backpressure();
      test_bad_meth();
      test_random();
      test_reset_mid_packet();
`ifdef BFP_ARB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
